button_debounce: RTL and testbench

Debounces and synchronises up to N active-low push-buttons into one clock domain. Produces clean active-high level outputs, one-cycle press/release pulses, and per-button 8-bit press counters. Sits directly upstream of the host endpoints: levels feed a WireOut status word, pulses feed an okTriggerOut `ep_trigger` vector on the same clock, and counters feed WireOuts. Control comes from a WireIn bit.

---
 rtl/button_debounce.sv | 108 ++++++++++
 tb/tb_button_debounce.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Synchronises and debounces N raw active-low push-buttons into the clk1
// domain. Each channel produces a clean active-high level, registered
// one-cycle press/release pulses and an 8-bit wrapping press counter.
//
// Ports:
//   clk1          in   1     sole clock, rising-edge
//   reset1        in   1     asynchronous active-high reset
//   button        in   N     raw active-low buttons, asynchronous to clk1
//   count_clr     in   1     synchronous level clear of every press counter
//   pressed       out  N     debounced level, 1 = held
//   press_pulse   out  N     one-cycle pulse as pressed[i] rises
//   release_pulse out  N     one-cycle pulse as pressed[i] falls
//   press_count   out  8*N   per-channel press count, channel i at [8i+7:8i]
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int N             = 4,
  parameter int STABLE_CYCLES = 100000,
  parameter int CNT_W         = 17
) (
  input  logic             clk1,
  input  logic             reset1,
  input  logic [N-1:0]     button,
  input  logic             count_clr,
  output logic [N-1:0]     pressed,
  output logic [N-1:0]     press_pulse,
  output logic [N-1:0]     release_pulse,
  output logic [8*N-1:0]   press_count
);

  // Terminal value of the stability counter: reaching it while the
  // synchronised level still differs means the new level has been seen for
  // STABLE_CYCLES consecutive edges and is accepted.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic             r_sync1;
    logic             r_sync2;
    logic             r_pressed;
    logic             r_press_pulse;
    logic             r_release_pulse;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_count;
    logic             w_differs;
    logic             w_accept;
    logic             w_rise;

    assign w_differs = r_sync2 ^ r_pressed;
    assign w_accept  = w_differs & (r_cnt == LP_LAST);
    assign w_rise    = w_accept & r_sync2;

    // Synchroniser stage: two flops, input inverted so 1 means held.
    always_ff @(posedge clk1 or posedge reset1) begin
      if (reset1) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= ~button[gi];
        r_sync2 <= r_sync1;
      end
    end

    // Stability stage: any return to the accepted level forgets the partial
    // count completely, so bounces never accumulate.
    always_ff @(posedge clk1 or posedge reset1) begin
      if (reset1) begin
        r_cnt     <= '0;
        r_pressed <= 1'b0;
      end else begin
        if (!w_differs || w_accept) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_accept) begin
          r_pressed <= r_sync2;
        end
      end
    end

    // Event stage: pulses and counter update on the same edge as the level,
    // so downstream sees level, pulse and count change together.
    always_ff @(posedge clk1 or posedge reset1) begin
      if (reset1) begin
        r_press_pulse   <= 1'b0;
        r_release_pulse <= 1'b0;
        r_count         <= '0;
      end else begin
        r_press_pulse   <= w_rise;
        r_release_pulse <= w_accept & ~r_sync2;
        // Clear wins over a coincident press; the counter wraps freely.
        if (count_clr) begin
          r_count <= '0;
        end else if (w_rise) begin
          r_count <= r_count + 8'd1;
        end
      end
    end

    assign pressed[gi]             = r_pressed;
    assign press_pulse[gi]         = r_press_pulse;
    assign release_pulse[gi]       = r_release_pulse;
    assign press_count[8*gi +: 8]  = r_count;
  end

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//
// Directed walk through reset, clean press, bounce, release, wrap/clear,
// simultaneous channels and mid-debounce reset, followed by randomised
// button activity. Every edge is mirrored in a sliding-window reference:
// a level change is accepted once the last STABLE_CYCLES synchroniser
// samples all disagree with the current accepted level.
// -----------------------------------------------------------------------------
module tb_button_debounce;

  localparam int N  = 4;
  localparam int SC = 4;

  logic           clk1 = 1'b0;
  logic           reset1;
  logic [N-1:0]   button;
  logic           count_clr;
  logic [N-1:0]   pressed;
  logic [N-1:0]   press_pulse;
  logic [N-1:0]   release_pulse;
  logic [8*N-1:0] press_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: hist[ch][0] is the most recent sample of ~button,
  // hist[ch][j] the one j edges earlier. The synchroniser output seen at an
  // edge is the sample taken two edges before, i.e. hist[ch][1].
  bit           m_hist [N][SC+1];
  logic [N-1:0] m_pressed;
  logic [N-1:0] m_pp;
  logic [N-1:0] m_rp;
  logic [7:0]   m_cnt  [N];

  button_debounce #(.N(N), .STABLE_CYCLES(SC), .CNT_W(3)) dut (
    .clk1          (clk1),
    .reset1        (reset1),
    .button        (button),
    .count_clr     (count_clr),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_count   (press_count)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      for (int j = 0; j <= SC; j++) m_hist[c][j] = 1'b0;
      m_cnt[c] = 8'd0;
    end
    m_pressed = '0;
    m_pp      = '0;
    m_rp      = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] btn, input logic clr);
    for (int c = 0; c < N; c++) begin
      bit flip;
      bit prev;
      prev = m_pressed[c];
      flip = 1'b1;
      for (int j = 1; j <= SC; j++) if (m_hist[c][j] == prev) flip = 1'b0;
      m_pp[c]      = flip & ~prev;
      m_rp[c]      = flip & prev;
      m_pressed[c] = prev ^ flip;
      if (clr)          m_cnt[c] = 8'd0;
      else if (m_pp[c]) m_cnt[c] = m_cnt[c] + 8'd1;
      for (int j = SC; j >= 1; j--) m_hist[c][j] = m_hist[c][j-1];
      m_hist[c][0] = ~btn[c];
    end
  endtask

  function automatic logic [31:0] m_count_vec();
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[8*c +: 8] = m_cnt[c];
    return v;
  endfunction

  task automatic check_model();
    chk("pressed",       32'(pressed),       32'(m_pressed));
    chk("press_pulse",   32'(press_pulse),   32'(m_pp));
    chk("release_pulse", 32'(release_pulse), 32'(m_rp));
    chk("press_count",   32'(press_count),   m_count_vec());
  endtask

  // One clock edge: reference consumes the inputs present at the edge, the
  // DUT is sampled 1 ns later.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk1);
      model_edge(button, count_clr);
      #1;
      check_model();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pressed"}, 32'(pressed),       32'd0);
    chk({tag, "_ppulse"},  32'(press_pulse),   32'd0);
    chk({tag, "_rpulse"},  32'(release_pulse), 32'd0);
    chk({tag, "_count"},   32'(press_count),   32'd0);
  endtask

  initial begin
    reset1    = 1'b0;
    button    = '1;
    count_clr = 1'b0;
    model_reset();

    // Reset asserted mid-cycle, then a clean press on channel 0.
    #2 reset1 = 1'b1;
    #1 check_all_zero("reset");
    model_reset();
    @(posedge clk1);
    @(posedge clk1);
    #3 reset1 = 1'b0;
    check_all_zero("reset_held");
    button = 4'b1110;
    step(5);
    chk("press0_not_yet", 32'(pressed), 32'd0);
    step(1);
    chk("press0_level", 32'(pressed),     32'b0001);
    chk("press0_pulse", 32'(press_pulse), 32'b0001);
    step(1);
    chk("press0_pulse_end", 32'(press_pulse),      32'd0);
    chk("press0_count",     32'(press_count[7:0]), 32'd1);

    // Bounce on channel 1: low 3, high 1, low 2, then released.
    button[1] = 1'b0; step(3);
    button[1] = 1'b1; step(1);
    button[1] = 1'b0; step(2);
    button[1] = 1'b1; step(10);
    chk("bounce_level", 32'(pressed[1]),        32'd0);
    chk("bounce_count", 32'(press_count[15:8]), 32'd0);

    // Release of channel 0.
    button[0] = 1'b1;
    step(6);
    chk("release_pulse0", 32'(release_pulse[0]), 32'd1);
    chk("release_level0", 32'(pressed[0]),       32'd0);
    chk("release_count0", 32'(press_count[7:0]), 32'd1);
    step(1);
    chk("release_pulse0_end", 32'(release_pulse[0]), 32'd0);

    // 256 presses on channel 2 wrap its counter back to zero.
    for (int p = 0; p < 256; p++) begin
      button[2] = 1'b0; step(7);
      button[2] = 1'b1; step(7);
    end
    chk("wrap_count2", 32'(press_count[23:16]), 32'h00);

    // 257th press with count_clr on the accepting edge.
    button[2] = 1'b0; step(5);
    count_clr = 1'b1; step(1);
    count_clr = 1'b0;
    chk("clr_pulse2", 32'(press_pulse[2]),     32'd1);
    chk("clr_count2", 32'(press_count[23:16]), 32'h00);
    button[2] = 1'b1; step(8);

    // Channels 0 and 3 pressed together.
    button = 4'b0110;
    step(6);
    chk("simul_pulse", 32'(press_pulse), 32'b1001);
    chk("simul_level", 32'(pressed),     32'b1001);
    button = 4'b1111; step(8);

    // Press again and reset when the stability count has reached 2.
    button = 4'b0110;
    step(4);
    #1 reset1 = 1'b1;
    #1 check_all_zero("midreset");
    model_reset();
    @(posedge clk1);
    #3 reset1 = 1'b0;
    step(5);
    chk("post_reset_not_yet", 32'(pressed), 32'd0);
    step(1);
    chk("post_reset_pulse",  32'(press_pulse),        32'b1001);
    chk("post_reset_count0", 32'(press_count[7:0]),   32'd1);
    chk("post_reset_count3", 32'(press_count[31:24]), 32'd1);

    // Randomised activity, including short bursts and occasional clears.
    for (int it = 0; it < 400; it++) begin
      int hold;
      button = N'($urandom);
      hold   = int'($urandom_range(1, 9));
      for (int h = 0; h < hold; h++) begin
        count_clr = ($urandom_range(0, 15) == 0);
        step(1);
      end
    end
    count_clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
